// File: rtl/rnd_flags_pkg.sv
// rnd_flags_pkg: format encodings and per-format rounding constants.
// Half precision constants exist only when RND_FLAGS_HALF_EN is defined.
package rnd_flags_pkg;

    typedef enum logic [1:0] {
        FMT_SP  = 2'b00,
        FMT_DP  = 2'b01,
        FMT_HP  = 2'b10,
        FMT_RSV = 2'b11
    } fmt_e;

    localparam int CW = 11;

    localparam logic [CW-1:0] BIAS_SP = 11'd127;
    localparam logic [CW-1:0] BIAS_DP = 11'd1023;
    localparam logic [CW-1:0] EMAX_SP = 11'd127;
    localparam logic [CW-1:0] EMAX_DP = 11'd1023;
`ifdef RND_FLAGS_HALF_EN
    localparam logic [CW-1:0] BIAS_HP = 11'd15;
    localparam logic [CW-1:0] EMAX_HP = 11'd15;
`endif

    function automatic logic [CW-1:0] bias_of(fmt_e f);
        logic [CW-1:0] b;
        b = '0;
        case (f)
            FMT_SP:  b = BIAS_SP;
            FMT_DP:  b = BIAS_DP;
`ifdef RND_FLAGS_HALF_EN
            FMT_HP:  b = BIAS_HP;
`endif
            default: b = '0;
        endcase
        return b;
    endfunction

    function automatic logic [CW-1:0] emax_of(fmt_e f);
        logic [CW-1:0] m;
        m = '0;
        case (f)
            FMT_SP:  m = EMAX_SP;
            FMT_DP:  m = EMAX_DP;
`ifdef RND_FLAGS_HALF_EN
            FMT_HP:  m = EMAX_HP;
`endif
            default: m = '0;
        endcase
        return m;
    endfunction

    // Formats that may raise TINY/OVF1; anything else is reserved.
    function automatic logic fmt_ok(fmt_e f);
        logic ok;
        ok = 1'b0;
        case (f)
            FMT_SP:  ok = 1'b1;
            FMT_DP:  ok = 1'b1;
`ifdef RND_FLAGS_HALF_EN
            FMT_HP:  ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rnd_lzc.sv
// rnd_lzc: combinational leading-zero counter.
// lz is W and zero is set when the input is all zeros.
module rnd_lzc #(
    parameter  int W   = 57,
    localparam int LZW = $clog2(W + 1)
) (
    input  logic [W-1:0]   d,
    output logic [LZW-1:0] lz,
    output logic           zero
);

    // Scan upward so the highest set bit determines the count.
    always_comb begin
        lz   = LZW'(W);
        zero = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (d[i]) begin
                lz   = LZW'(W - 1 - i);
                zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rnd_flags_pipe.sv
// rnd_flags_pipe: 2-stage elastic pre-rounding TINY/OVF1 detector.
// Define RND_FLAGS_HALF_EN to accept fmt=10 as half precision.
module rnd_flags_pipe
    import rnd_flags_pkg::*;
#(
    parameter  int FW  = 57,
    parameter  int EW  = 13,
    localparam int LZW = $clog2(FW + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [FW-1:0]  fr,
    input  logic [EW-1:0]  er,
    input  logic [1:0]     fmt,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [LZW-1:0] lz,
    output logic           zero,
    output logic           tiny,
    output logic           ovf1,
    output logic [1:0]     fmt_o,
    input  logic           clr_sticky,
    output logic           tiny_sticky,
    output logic           ovf_sticky
);

    logic           w_s1_adv;
    logic           w_s2_adv;
    logic           w_fire;
    logic [LZW-1:0] w_lz;
    logic           w_zero;

    logic           r_s1_valid;
    logic           r_s1_msb;
    logic [EW-1:0]  r_s1_er;
    fmt_e           r_s1_fmt;
    logic [LZW-1:0] r_s1_lz;
    logic           r_s1_zero;

    logic           r_s2_valid;
    logic [LZW-1:0] r_lz;
    logic           r_zero;
    logic           r_tiny;
    logic           r_ovf1;
    logic [1:0]     r_fmt;
    logic           r_tiny_sticky;
    logic           r_ovf_sticky;

    logic [CW-1:0]  w_bias;
    logic [CW-1:0]  w_emax;
    logic           w_fmt_ok;
    logic [EW:0]    w_bias_x;
    logic [EW:0]    w_lz_x;
    logic [EW:0]    w_t;
    logic [EW-1:0]  w_emax_x;
    logic           w_er_gt;
    logic           w_er_eq;
    logic           w_tiny;
    logic           w_ovf1;

    rnd_lzc #(.W(FW)) u_lzc (
        .d    (fr),
        .lz   (w_lz),
        .zero (w_zero)
    );

    assign w_s2_adv = !r_s2_valid | out_ready;
    assign w_s1_adv = !r_s1_valid | w_s2_adv;
    assign w_fire   = r_s2_valid & out_ready;
    assign in_ready = w_s1_adv;

    assign w_bias   = bias_of(r_s1_fmt);
    assign w_emax   = emax_of(r_s1_fmt);
    assign w_fmt_ok = fmt_ok(r_s1_fmt);

    // Biased exponent after normalisation, one guard bit for the sign.
    assign w_bias_x = {{(EW + 1 - CW){1'b0}}, w_bias};
    assign w_lz_x   = {{(EW + 1 - LZW){1'b0}}, r_s1_lz};
    assign w_t      = {r_s1_er[EW-1], r_s1_er} - w_lz_x + w_bias_x;
    assign w_tiny   = w_fmt_ok & ~r_s1_zero & w_t[EW];

    assign w_emax_x = {{(EW - CW){1'b0}}, w_emax};
    assign w_er_gt  = $signed(r_s1_er) > $signed(w_emax_x);
    assign w_er_eq  = r_s1_er == w_emax_x;
    assign w_ovf1   = w_fmt_ok & ~r_s1_zero &
                      (w_er_gt | (w_er_eq & r_s1_msb));

    // Stage 1: capture the beat together with its leading-zero count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_msb   <= 1'b0;
            r_s1_er    <= '0;
            r_s1_fmt   <= FMT_SP;
            r_s1_lz    <= '0;
            r_s1_zero  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_msb  <= fr[FW-1];
                r_s1_er   <= er;
                r_s1_fmt  <= fmt_e'(fmt);
                r_s1_lz   <= w_lz;
                r_s1_zero <= w_zero;
            end
        end
    end

    // Stage 2: register the flags; a stalled beat keeps its outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_lz       <= '0;
            r_zero     <= 1'b0;
            r_tiny     <= 1'b0;
            r_ovf1     <= 1'b0;
            r_fmt      <= 2'b00;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_lz   <= r_s1_lz;
                r_zero <= r_s1_zero;
                r_tiny <= w_tiny;
                r_ovf1 <= w_ovf1;
                r_fmt  <= r_s1_fmt;
            end
        end
    end

    // Sticky status: a delivered set flag beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tiny_sticky <= 1'b0;
            r_ovf_sticky  <= 1'b0;
        end else begin
            r_tiny_sticky <= (r_tiny_sticky & ~clr_sticky) |
                             (w_fire & r_tiny);
            r_ovf_sticky  <= (r_ovf_sticky & ~clr_sticky) |
                             (w_fire & r_ovf1);
        end
    end

    assign out_valid   = r_s2_valid;
    assign lz          = r_lz;
    assign zero        = r_zero;
    assign tiny        = r_tiny;
    assign ovf1        = r_ovf1;
    assign fmt_o       = r_fmt;
    assign tiny_sticky = r_tiny_sticky;
    assign ovf_sticky  = r_ovf_sticky;

endmodule

// File: tb/tb_rnd_flags_pipe.sv
// tb_rnd_flags_pipe: directed and random checks of rnd_flags_pipe
// against a reference model built from the format rules.
module tb_rnd_flags_pipe;

    localparam int FW = 57;
    localparam int EW = 13;
    localparam logic [FW-1:0] B55 = 57'h080_0000_0000_0000;
    localparam logic [FW-1:0] B56 = 57'h100_0000_0000_0000;
`ifdef RND_FLAGS_HALF_EN
    localparam bit HALF = 1'b1;
`else
    localparam bit HALF = 1'b0;
`endif

    typedef struct packed {
        logic [5:0] lz;
        logic       zero;
        logic       tiny;
        logic       ovf;
        logic [1:0] fmt;
    } exp_t;

    typedef struct packed {
        logic [FW-1:0] fr;
        logic [EW-1:0] er;
        logic [1:0]    fmt;
        logic [5:0]    lz;
        logic          zero;
        logic          tiny;
        logic          ovf;
    } dir_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] fr;
    logic [EW-1:0] er;
    logic [1:0]    fmt;
    logic          out_valid;
    logic          out_ready;
    logic [5:0]    lz;
    logic          zero;
    logic          tiny;
    logic          ovf1;
    logic [1:0]    fmt_o;
    logic          clr_sticky;
    logic          tiny_sticky;
    logic          ovf_sticky;

    int   checks;
    int   failures;
    bit   exp_ts;
    bit   exp_os;
    exp_t exp_q[$];

    rnd_flags_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .fr          (fr),
        .er          (er),
        .fmt         (fmt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .lz          (lz),
        .zero        (zero),
        .tiny        (tiny),
        .ovf1        (ovf1),
        .fmt_o       (fmt_o),
        .clr_sticky  (clr_sticky),
        .tiny_sticky (tiny_sticky),
        .ovf_sticky  (ovf_sticky)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic exp_t model(logic [FW-1:0] f,
                                   logic signed [EW-1:0] e,
                                   logic [1:0] m);
        exp_t r;
        int   n;
        int   bias;
        int   emax;
        int   t;
        bit   ok;
        n = 0;
        while (n < FW && f[FW-1-n] == 1'b0) n++;
        ok   = 1'b1;
        bias = 0;
        case (m)
            2'b00:   bias = 127;
            2'b01:   bias = 1023;
            2'b10:   begin
                         if (HALF) bias = 15;
                         else ok = 1'b0;
                     end
            default: ok = 1'b0;
        endcase
        emax   = bias;
        t      = int'(e) - n + bias;
        r.lz   = 6'(n);
        r.zero = (f == '0);
        r.tiny = ok && (f != '0) && (t < 0);
        r.ovf  = ok && (f != '0) &&
                 ((int'(e) > emax) || (int'(e) == emax && f[FW-1]));
        r.fmt  = m;
        return r;
    endfunction

    task automatic rand_inputs();
        logic [63:0] w;
        w  = {$urandom, $urandom};
        fr = FW'(w >> $urandom_range(0, 60));
        if ($urandom_range(0, 15) == 0) fr = '0;
        case ($urandom_range(0, 2))
            0:       er = EW'($urandom);
            1:       er = EW'(int'($urandom_range(0, 2200)) - 1100);
            default: er = EW'(int'($urandom_range(0, 300)) - 150);
        endcase
        fmt = 2'($urandom_range(0, 3));
    endtask

    task automatic do_clear();
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        exp_ts = 1'b0;
        exp_os = 1'b0;
    endtask

    // Sends one beat into an empty pipe; returns at the negedge where
    // out_valid is first seen, with lat in cycles after acceptance.
    task automatic send_beat(input logic [FW-1:0] f,
                             input logic [EW-1:0] e,
                             input logic [1:0] m,
                             output int lat);
        int c;
        fr = f;
        er = e;
        fmt = m;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        c = 0;
        while (lat < 0 && c < 8) begin
            c++;
            @(negedge clk);
            if (out_valid === 1'b1) lat = c;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        clr_sticky = 1'b0;
        fr = '0;
        er = '0;
        fmt = 2'b00;
        exp_ts = 1'b0;
        exp_os = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid: got %0b want 0", out_valid);
        end
        checks++;
        if ({lz, zero, tiny, ovf1, fmt_o} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %0h want 0",
                     {lz, zero, tiny, ovf1, fmt_o});
        end
        checks++;
        if ({tiny_sticky, ovf_sticky} !== 2'b00) begin
            failures++;
            $display("FAIL reset_sticky: got %0b want 00",
                     {tiny_sticky, ovf_sticky});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        dir_t rows[$];
        dir_t r;
        int   lat;
        rows.push_back('{B55, EW'(-1022), 2'b01, 6'd1, 1'b0, 1'b0, 1'b0});
        rows.push_back('{B55, EW'(-1023), 2'b01, 6'd1, 1'b0, 1'b1, 1'b0});
        rows.push_back('{B55, EW'(-127),  2'b00, 6'd1, 1'b0, 1'b1, 1'b0});
        rows.push_back('{B56, EW'(127),   2'b00, 6'd0, 1'b0, 1'b0, 1'b1});
        rows.push_back('{B55, EW'(127),   2'b00, 6'd1, 1'b0, 1'b0, 1'b0});
        rows.push_back('{B55, EW'(128),   2'b00, 6'd1, 1'b0, 1'b0, 1'b1});
        rows.push_back('{B55, EW'(1024),  2'b01, 6'd1, 1'b0, 1'b0, 1'b1});
        rows.push_back('{'0,  EW'(5000),  2'b01, 6'd57, 1'b1, 1'b0, 1'b0});
        rows.push_back('{B55, EW'(16),    2'b10, 6'd1, 1'b0, 1'b0, HALF});
        rows.push_back('{B55, EW'(2000),  2'b11, 6'd1, 1'b0, 1'b0, 1'b0});
        rows.push_back('{B55, EW'(-2000), 2'b11, 6'd1, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < rows.size(); i++) begin
            r = rows[i];
            send_beat(r.fr, r.er, r.fmt, lat);
            checks++;
            if (lat !== 2) begin
                failures++;
                $display("FAIL dir%0d_latency: got %0d want 2", i, lat);
            end
            checks++;
            if ({lz, zero, tiny, ovf1, fmt_o} !==
                {r.lz, r.zero, r.tiny, r.ovf, r.fmt}) begin
                failures++;
                $display("FAIL dir%0d_flags: got lz=%0d z=%0b t=%0b o=%0b f=%0d want lz=%0d z=%0b t=%0b o=%0b f=%0d",
                         i, lz, zero, tiny, ovf1, fmt_o,
                         r.lz, r.zero, r.tiny, r.ovf, r.fmt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sticky();
        int lat;
        do_clear();
        checks++;
        if ({tiny_sticky, ovf_sticky} !== 2'b00) begin
            failures++;
            $display("FAIL sticky_init: got %0b want 00",
                     {tiny_sticky, ovf_sticky});
        end
        send_beat(B55, EW'(128), 2'b00, lat);
        @(posedge clk); #1;
        checks++;
        if ({tiny_sticky, ovf_sticky} !== 2'b01) begin
            failures++;
            $display("FAIL sticky_ovf_set: got %0b want 01",
                     {tiny_sticky, ovf_sticky});
        end
        send_beat(B55, EW'(-127), 2'b00, lat);
        @(posedge clk); #1;
        checks++;
        if ({tiny_sticky, ovf_sticky} !== 2'b11) begin
            failures++;
            $display("FAIL sticky_tiny_set: got %0b want 11",
                     {tiny_sticky, ovf_sticky});
        end
        send_beat(B55, EW'(128), 2'b00, lat);
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        checks++;
        if ({tiny_sticky, ovf_sticky} !== 2'b01) begin
            failures++;
            $display("FAIL sticky_clr_with_set: got %0b want 01",
                     {tiny_sticky, ovf_sticky});
        end
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        checks++;
        if ({tiny_sticky, ovf_sticky} !== 2'b00) begin
            failures++;
            $display("FAIL sticky_clr_alone: got %0b want 00",
                     {tiny_sticky, ovf_sticky});
        end
        exp_ts = 1'b0;
        exp_os = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t held;
        int   sent;
        int   got;
        int   cyc;
        int   stall_left;
        bit   first;
        bit   stalled;
        bit   saw_low;
        exp_q.delete();
        sent = 0; got = 0; cyc = 0; stall_left = 0;
        first = 1'b0; stalled = 1'b0; saw_low = 1'b0;
        held = '0;
        while (got < 4 && cyc < 40) begin
            in_valid = (sent < 4);
            rand_inputs();
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 ||
                    {lz, zero, tiny, ovf1, fmt_o} !== held) begin
                    failures++;
                    $display("FAIL b2b_stall_hold: got v=%0b %0h want v=1 %0h",
                             out_valid, {lz, zero, tiny, ovf1, fmt_o}, held);
                end
            end
            if (in_valid && !in_ready) saw_low = 1'b1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_spurious: got beat want none");
                end else begin
                    e = exp_q.pop_front();
                    if ({lz, zero, tiny, ovf1, fmt_o} !== e) begin
                        failures++;
                        $display("FAIL b2b_beat%0d: got %0h want %0h",
                                 got, {lz, zero, tiny, ovf1, fmt_o}, e);
                    end
                    exp_ts |= e.tiny;
                    exp_os |= e.ovf;
                    got++;
                end
                if (!first) begin
                    first = 1'b1;
                    stall_left = 3;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(fr, er, fmt));
                sent++;
            end
            stalled = out_valid && !out_ready;
            held = {lz, zero, tiny, ovf1, fmt_o};
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got !== 4) begin
            failures++;
            $display("FAIL b2b_count: got %0d want 4", got);
        end
        checks++;
        if (saw_low !== 1'b1) begin
            failures++;
            $display("FAIL b2b_in_ready_low: got %0b want 1", saw_low);
        end
    endtask

    task automatic test_random(int n);
        exp_t e;
        exp_t held;
        int   sent;
        int   got;
        int   cyc;
        bit   stalled;
        do_clear();
        exp_q.delete();
        sent = 0; got = 0; cyc = 0; stalled = 1'b0;
        held = '0;
        while ((sent < n || got < sent) && cyc < 20 * n) begin
            in_valid = (sent < n) && ($urandom_range(0, 3) != 0);
            rand_inputs();
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 ||
                    {lz, zero, tiny, ovf1, fmt_o} !== held) begin
                    failures++;
                    $display("FAIL rand_stall_hold: got v=%0b %0h want v=1 %0h",
                             out_valid, {lz, zero, tiny, ovf1, fmt_o}, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_spurious: got beat want none");
                end else begin
                    e = exp_q.pop_front();
                    if ({lz, zero, tiny, ovf1, fmt_o} !== e) begin
                        failures++;
                        $display("FAIL rand_beat%0d: got %0h want %0h",
                                 got, {lz, zero, tiny, ovf1, fmt_o}, e);
                    end
                    exp_ts |= e.tiny;
                    exp_os |= e.ovf;
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(fr, er, fmt));
                sent++;
            end
            stalled = out_valid && !out_ready;
            held = {lz, zero, tiny, ovf1, fmt_o};
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got !== n) begin
            failures++;
            $display("FAIL rand_count: got %0d want %0d", got, n);
        end
        checks++;
        if ({tiny_sticky, ovf_sticky} !== {exp_ts, exp_os}) begin
            failures++;
            $display("FAIL rand_sticky: got %0b want %0b",
                     {tiny_sticky, ovf_sticky}, {exp_ts, exp_os});
        end
    endtask

    task automatic test_async_reset();
        int lat;
        bit saw;
        send_beat(B56, EW'(127), 2'b00, lat);
        @(posedge clk); #1;
        send_beat(B55, EW'(-127), 2'b00, lat);
        @(posedge clk); #1;
        checks++;
        if ({tiny_sticky, ovf_sticky} !== 2'b11) begin
            failures++;
            $display("FAIL ar_pre_sticky: got %0b want 11",
                     {tiny_sticky, ovf_sticky});
        end
        fr = B56;
        er = EW'(200);
        fmt = 2'b00;
        in_valid = 1'b1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL ar_inflight: got %0b want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ar_out_valid: got %0b want 0", out_valid);
        end
        checks++;
        if ({tiny_sticky, ovf_sticky} !== 2'b00) begin
            failures++;
            $display("FAIL ar_sticky: got %0b want 00",
                     {tiny_sticky, ovf_sticky});
        end
        checks++;
        if ({lz, zero, tiny, ovf1, fmt_o} !== 11'd0) begin
            failures++;
            $display("FAIL ar_outputs: got %0h want 0",
                     {lz, zero, tiny, ovf1, fmt_o});
        end
        exp_ts = 1'b0;
        exp_os = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid !== 1'b0) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            failures++;
            $display("FAIL ar_no_replay: got %0b want 0", saw);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_sticky();
        test_back_to_back();
        test_random(300);
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
